// File: rtl/fma16_issue_ctrl.sv
// Issue controller sharing one pipelined fma16 unit between NREQ requesters.
// Optional build macro FMA16_ISSUE_PERF_EN adds grant/conflict performance counters.
module fma16_issue_ctrl #(
    parameter int NREQ = 2,
    parameter int LAT  = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ*16-1:0]   req_x,
    input  logic [NREQ*16-1:0]   req_y,
    input  logic [NREQ*16-1:0]   req_z,
    input  logic [NREQ*6-1:0]    req_ctl,
    output logic                 fma_valid,
    output logic [15:0]          fma_x,
    output logic [15:0]          fma_y,
    output logic [15:0]          fma_z,
    output logic [5:0]           fma_ctl,
    input  logic [15:0]          fma_result,
    input  logic [3:0]           fma_flags,
    output logic [NREQ-1:0]      rsp_valid,
    input  logic [NREQ-1:0]      rsp_ready,
    output logic [NREQ*16-1:0]   rsp_result,
    output logic [NREQ*4-1:0]    rsp_flags
`ifdef FMA16_ISSUE_PERF_EN
    ,
    output logic [15:0]          perf_issued,
    output logic [15:0]          perf_conflict
`endif
);

    localparam int IDW = $clog2(NREQ);

    logic [IDW-1:0]  ptr;
    logic [NREQ-1:0] busy;
    logic [NREQ-1:0] eligible;
    logic            grant_any;
    logic            grant;
    logic [IDW-1:0]  grant_id;
    logic            cap_vld;
    logic [IDW-1:0]  cap_id;

    assign eligible = req_valid & ~busy;
    assign grant    = grant_any & ~reset;

    // Rotating-priority search: first eligible requester at or above ptr, wrapping.
    always_comb begin
        logic [IDW:0] cand;
        grant_any = 1'b0;
        grant_id  = '0;
        cand      = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand = {1'b0, ptr} + (IDW+1)'(k);
            if (cand >= (IDW+1)'(NREQ))
                cand = cand - (IDW+1)'(NREQ);
            if (!grant_any && eligible[cand[IDW-1:0]]) begin
                grant_any = 1'b1;
                grant_id  = cand[IDW-1:0];
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (grant)
            req_ready[grant_id] = 1'b1;
    end

    // Stage p0 -> issue register: operands of the granted requester go to the shared unit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr       <= '0;
            fma_valid <= 1'b0;
            fma_x     <= '0;
            fma_y     <= '0;
            fma_z     <= '0;
            fma_ctl   <= '0;
        end else begin
            fma_valid <= grant;
            if (grant) begin
                ptr     <= (grant_id == IDW'(NREQ-1)) ? '0 : grant_id + 1'b1;
                fma_x   <= req_x[16*grant_id +: 16];
                fma_y   <= req_y[16*grant_id +: 16];
                fma_z   <= req_z[16*grant_id +: 16];
                fma_ctl <= req_ctl[6*grant_id +: 6];
            end
        end
    end

    // Tag pipe mirrors the unit latency; with LAT=0 the unit result is taken on the grant edge.
    generate
        if (LAT == 0) begin : g_comb
            assign cap_vld = grant;
            assign cap_id  = grant_id;
        end else begin : g_pipe
            logic [LAT-1:0] tag_vld_p;
            logic [IDW-1:0] tag_id_p [LAT];

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    tag_vld_p <= '0;
                    for (int s = 0; s < LAT; s++)
                        tag_id_p[s] <= '0;
                end else begin
                    tag_vld_p[0] <= grant;
                    tag_id_p[0]  <= grant_id;
                    for (int s = 1; s < LAT; s++) begin
                        tag_vld_p[s] <= tag_vld_p[s-1];
                        tag_id_p[s]  <= tag_id_p[s-1];
                    end
                end
            end

            assign cap_vld = tag_vld_p[LAT-1];
            assign cap_id  = tag_id_p[LAT-1];
        end
    endgenerate

    // Response stage: capture by tag id, hold until the requester accepts.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy       <= '0;
            rsp_valid  <= '0;
            rsp_result <= '0;
            rsp_flags  <= '0;
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                if (grant && grant_id == IDW'(i))
                    busy[i] <= 1'b1;
                else if (rsp_valid[i] && rsp_ready[i])
                    busy[i] <= 1'b0;

                if (cap_vld && cap_id == IDW'(i)) begin
                    rsp_valid[i]          <= 1'b1;
                    rsp_result[16*i +: 16] <= fma_result;
                    rsp_flags[4*i +: 4]    <= fma_flags;
                end else if (rsp_valid[i] && rsp_ready[i]) begin
                    rsp_valid[i] <= 1'b0;
                end
            end
        end
    end

`ifdef FMA16_ISSUE_PERF_EN
    logic conflict;
    assign conflict = |(eligible & (eligible - 1'b1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_issued   <= '0;
            perf_conflict <= '0;
        end else begin
            if (grant && perf_issued != 16'hFFFF)
                perf_issued <= perf_issued + 1'b1;
            if (conflict && perf_conflict != 16'hFFFF)
                perf_conflict <= perf_conflict + 1'b1;
        end
    end
`endif

endmodule
